// File: rtl/microcode_sequencer.sv
// T-state sequencer and microcode decoder for the 8-bit SAP-style CPU.
// Optional build macro: MICROCODE_SEQUENCER_VARIABLE_CYCLE_EN (ends each instruction after its last active step).
module microcode_sequencer #(
  parameter int          NUM_T     = 6,
  parameter logic [14:0] CTRL_IDLE = 15'h0FE3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic [3:0]  opcode,
  input  logic        cf,
  input  logic        zf,
  output logic [14:0] ctrl,
  output logic [2:0]  t_state,
  output logic        halted
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5
  } t_state_e;

  localparam logic [2:0] T_LAST = 3'(NUM_T - 1);

  localparam int B_CP   = 14;
  localparam int B_EP   = 13;
  localparam int B_LP   = 12;
  localparam int B_NLMA = 11;
  localparam int B_NLMD = 10;
  localparam int B_NCE  = 9;
  localparam int B_NLR  = 8;
  localparam int B_NLI  = 7;
  localparam int B_NEI  = 6;
  localparam int B_NLA  = 5;
  localparam int B_EA   = 4;
  localparam int B_SUB  = 3;
  localparam int B_EU   = 2;
  localparam int B_NLB  = 1;
  localparam int B_NLO  = 0;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  t_state_e    t_state_r;
  t_state_e    t_next_s;
  logic        halted_r;
  logic        last_step_s;
  logic        halt_now_s;
  logic [14:0] word_s;

  assign t_state = t_state_r;
  assign halted  = halted_r;

  // Microcode ROM: control word for the current step, before advance/halt gating.
  always_comb begin
    word_s = CTRL_IDLE;
    case (t_state_r)
      T0: begin
        word_s[B_EP]   = 1'b1;
        word_s[B_NLMA] = 1'b0;
      end
      T1: word_s[B_CP] = 1'b1;
      T2: begin
        word_s[B_NCE] = 1'b0;
        word_s[B_NLI] = 1'b0;
      end
      T3: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            word_s[B_NEI]  = 1'b0;
            word_s[B_NLMA] = 1'b0;
          end
          OP_LDI: begin
            word_s[B_NEI] = 1'b0;
            word_s[B_NLA] = 1'b0;
          end
          OP_JMP: begin
            word_s[B_NEI] = 1'b0;
            word_s[B_LP]  = 1'b1;
          end
          OP_JC, OP_JZ: begin
            // Conditional jumps look at the flags only here, in T3.
            if ((opcode == OP_JC) ? cf : zf) begin
              word_s[B_NEI] = 1'b0;
              word_s[B_LP]  = 1'b1;
            end else begin
              word_s = CTRL_IDLE;
            end
          end
          OP_OUT: begin
            word_s[B_EA]  = 1'b1;
            word_s[B_NLO] = 1'b0;
          end
          default: word_s = CTRL_IDLE;
        endcase
      end
      T4: begin
        case (opcode)
          OP_LDA: begin
            word_s[B_NCE] = 1'b0;
            word_s[B_NLA] = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            word_s[B_NCE] = 1'b0;
            word_s[B_NLB] = 1'b0;
          end
          OP_STA: begin
            word_s[B_EA]   = 1'b1;
            word_s[B_NLMD] = 1'b0;
          end
          default: word_s = CTRL_IDLE;
        endcase
      end
      T5: begin
        case (opcode)
          OP_ADD, OP_SUB: begin
            word_s[B_EU]  = 1'b1;
            word_s[B_NLA] = 1'b0;
            word_s[B_SUB] = (opcode == OP_SUB);
          end
          OP_STA: word_s[B_NLR] = 1'b0;
          default: word_s = CTRL_IDLE;
        endcase
      end
      default: word_s = CTRL_IDLE;
    endcase
  end

  // Output gating: reset, stall and halt all present an idle word so no strobe double-fires.
  always_comb begin
    if (rst || !advance || halted_r) begin
      ctrl = CTRL_IDLE;
    end else begin
      ctrl = word_s;
    end
  end

  // Decides whether the current step is the final one of the instruction.
  always_comb begin
    last_step_s = (t_state == T_LAST);
`ifdef MICROCODE_SEQUENCER_VARIABLE_CYCLE_EN
    case (t_state_r)
      T3: last_step_s = !(opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_STA});
      T4: last_step_s = !(opcode inside {OP_ADD, OP_SUB, OP_STA});
      T5: last_step_s = 1'b1;
      default: last_step_s = 1'b0;
    endcase
`else
    if (t_state == T_LAST) begin
      last_step_s = 1'b1;
    end else begin
      last_step_s = 1'b0;
    end
`endif
  end

  // Successor state and halt detection.
  always_comb begin
    halt_now_s = (t_state_r == T3) && (opcode == OP_HLT);
    case (t_state_r)
      T0: t_next_s = T1;
      T1: t_next_s = T2;
      T2: t_next_s = T3;
      T3: t_next_s = T4;
      T4: t_next_s = T5;
      T5: t_next_s = T0;
      default: t_next_s = T0;
    endcase
    if (halt_now_s || last_step_s) begin
      t_next_s = T0;
    end else begin
      t_next_s = t_next_s;
    end
  end

  // Sequencer state: steps only when advancing and not halted; only reset clears halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_state_r <= T0;
      halted_r  <= 1'b0;
    end else if (advance && !halted_r) begin
      t_state_r <= t_next_s;
      halted_r  <= halt_now_s;
    end else begin
      t_state_r <= t_state_r;
      halted_r  <= halted_r;
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Randomized and directed bench for microcode_sequencer against a behavioural instruction model.
module tb_microcode_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        advance = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        cf = 1'b0;
  logic        zf = 1'b0;
  logic [14:0] ctrl;
  logic [2:0]  t_state;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: step within instruction and halt flag.
  int m_t = 0;
  bit m_h = 1'b0;

  localparam logic [14:0] IDLE = 15'h0FE3;
  // Toggle masks: asserting a signal flips its idle level.
  localparam logic [14:0] CP = 15'h4000, EP = 15'h2000, LP = 15'h1000, LMA = 15'h0800,
                          LMD = 15'h0400, CE = 15'h0200, LR = 15'h0100, LI = 15'h0080,
                          EI = 15'h0040, LA = 15'h0020, EA = 15'h0010, SB = 15'h0008,
                          EU = 15'h0004, LB = 15'h0002, LO = 15'h0001;

  microcode_sequencer dut (
    .clk(clk), .rst(rst), .advance(advance), .opcode(opcode),
    .cf(cf), .zf(zf), .ctrl(ctrl), .t_state(t_state), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] step_mask(input int t, input logic [3:0] op, input bit c, input bit z);
    if (t == 0) return EP | LMA;
    if (t == 1) return CP;
    if (t == 2) return CE | LI;
    case (op)
      4'h1: return (t == 3) ? (EI | LMA) : (t == 4) ? (CE | LA) : 15'h0000;
      4'h2, 4'h3: return (t == 3) ? (EI | LMA) : (t == 4) ? (CE | LB) :
                         ((op == 4'h3) ? (EU | LA | SB) : (EU | LA));
      4'h4: return (t == 3) ? (EI | LMA) : (t == 4) ? (EA | LMD) : LR;
      4'h5: return (t == 3) ? (EI | LA) : 15'h0000;
      4'h6: return (t == 3) ? (EI | LP) : 15'h0000;
      4'h7: return (t == 3 && c) ? (EI | LP) : 15'h0000;
      4'h8: return (t == 3 && z) ? (EI | LP) : 15'h0000;
      4'hE: return (t == 3) ? (EA | LO) : 15'h0000;
      default: return 15'h0000;
    endcase
  endfunction

  function automatic int instr_len(input logic [3:0] op);
`ifdef MICROCODE_SEQUENCER_VARIABLE_CYCLE_EN
    if (op == 4'h1) return 5;
    if (op == 4'h2 || op == 4'h3 || op == 4'h4) return 6;
    return 4;
`else
    return 6;
`endif
  endfunction

  // One clock: drive inputs, check outputs on the falling edge, advance the model on the rising edge.
  task automatic cyc(input bit r, input bit a, input logic [3:0] o, input bit c, input bit z);
    logic [14:0] exp_ctrl;
    logic        bus_bad;
    rst = r; advance = a; opcode = o; cf = c; zf = z;
    @(negedge clk);
    exp_ctrl = (r || !a || m_h) ? IDLE : (IDLE ^ step_mask(m_t, o, c, z));
    check_eq("ctrl", {1'b0, ctrl}, {1'b0, exp_ctrl});
    check_eq("t_state", {13'd0, t_state}, 16'(m_t));
    check_eq("halted", {15'd0, halted}, {15'd0, m_h});
    bus_bad = (ctrl[4] | ctrl[2]) & (~ctrl[9] | ~ctrl[6]);
    check_eq("bus_driver", {15'd0, bus_bad}, 16'd0);
    @(posedge clk);
    if (r) begin
      m_t = 0; m_h = 1'b0;
    end else if (a && !m_h) begin
      if (m_t == 3 && o == 4'hF) begin
        m_h = 1'b1; m_t = 0;
      end else if (m_t >= instr_len(o) - 1) begin
        m_t = 0;
      end else begin
        m_t = m_t + 1;
      end
    end
    #1;
  endtask

  task automatic run_instr(input logic [3:0] o, input bit c, input bit z);
    int len;
    len = (o == 4'hF) ? 4 : instr_len(o);
    for (int i = 0; i < len; i++) cyc(1'b0, 1'b1, o, c, z);
  endtask

  initial begin
    @(posedge clk); #1;
    m_t = 0; m_h = 1'b0;
    cyc(1'b1, 1'b1, 4'h5, 1'b0, 1'b0);

    // Fetch word spot checks against literal values.
    rst = 1'b0; advance = 1'b1; opcode = 4'h5;
    @(negedge clk); check_eq("ldi_t0", {1'b0, ctrl}, 16'h27E3);
    @(posedge clk); m_t = 1; #1;
    @(negedge clk); check_eq("ldi_t1", {1'b0, ctrl}, 16'h4FE3);
    @(posedge clk); m_t = 2; #1;
    @(negedge clk); check_eq("ldi_t2", {1'b0, ctrl}, 16'h0D63);
    @(posedge clk); m_t = 3; #1;
    @(negedge clk); check_eq("ldi_t3", {1'b0, ctrl}, 16'h0F83);
    @(posedge clk); m_t = (instr_len(4'h5) == 4) ? 0 : 4; #1;
    while (m_t != 0) cyc(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
    check_eq("ldi_wrap", {13'd0, t_state}, 16'd0);

    run_instr(4'h3, 1'b0, 1'b0);
    run_instr(4'h2, 1'b1, 1'b1);
    run_instr(4'h7, 1'b1, 1'b0);
    run_instr(4'h7, 1'b0, 1'b1);
    run_instr(4'h8, 1'b0, 1'b1);
    run_instr(4'h8, 1'b1, 1'b0);
    run_instr(4'h1, 1'b0, 1'b0);
    run_instr(4'hE, 1'b0, 1'b0);
    run_instr(4'h6, 1'b0, 1'b0);
    run_instr(4'hB, 1'b0, 1'b0);

    // Stall at T1 for three cycles, then resume.
    cyc(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'h5, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
    check_eq("resume_t2", {13'd0, t_state}, 16'd2);
    while (m_t != 0) cyc(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);

    // Halt, stay halted, then reset out of it.
    run_instr(4'hF, 1'b0, 1'b0);
    check_eq("halt_set", {15'd0, halted}, 16'd1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 4'h0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    check_eq("halt_clr", {15'd0, halted}, 16'd0);
    cyc(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);

    // Reset in the middle of STA abandons it.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'h4, 1'b0, 1'b0);
    check_eq("sta_abort", {13'd0, t_state}, 16'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
          4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
